// File: rtl/multi_alarm_clock.sv
// 24h BCD time-of-day clock with NUM_ALARMS alarm channels, ring timeout and optional snooze.
// Build option: define SNOOZE_EN to add the per-channel SNOOZE state and snooze counter.
module multi_alarm_clock #(
   parameter  int NUM_ALARMS  = 4,
   parameter  int CLK_PER_SEC = 1,
   parameter  int RING_SEC    = 60,
   parameter  int SNOOZE_MIN  = 5,
   localparam int AW          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            hour_in1,
   input  logic [3:0]            hour_in0,
   input  logic [3:0]            min_in1,
   input  logic [3:0]            min_in0,
   input  logic                  time_set,
   input  logic                  alarm_set,
   input  logic [AW-1:0]         alarm_sel,
   input  logic [NUM_ALARMS-1:0] alarm_on,
   input  logic                  stop,
   input  logic                  snooze,
   output logic [NUM_ALARMS-1:0] alarm,
   output logic                  alarm_any,
   output logic                  set_err,
   output logic [1:0]            hour_out1,
   output logic [3:0]            hour_out0,
   output logic [3:0]            min_out1,
   output logic [3:0]            min_out0,
   output logic [3:0]            sec_out1,
   output logic [3:0]            sec_out0
);

   localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RING = 2'd1;
`ifdef SNOOZE_EN
   localparam logic [1:0] ST_SNZ  = 2'd2;
   localparam int SNZ_TICKS = SNOOZE_MIN * 60;
   localparam int SW = (SNZ_TICKS > 1) ? $clog2(SNZ_TICKS) : 1;
`else
   logic unused_snz;
   assign unused_snz = snooze | (SNOOZE_MIN < 1);
`endif

   logic [PW-1:0] pre_q, pre_d;
   logic [1:0]    h1_q, h1_d;
   logic [3:0]    h0_q, h0_d, m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;
   logic [NUM_ALARMS-1:0][13:0] alm_q;
   logic [NUM_ALARMS-1:0]       ring;
   logic [NUM_ALARMS-1:0]       alarm_q;
   logic                        alarm_any_q, set_err_q, set_err_d;

   logic hr_ok, in_ok, sel_ok, ts_ok, as_ok, tick, adv, min_tick;
   logic [13:0] in_vec, t_next;

   assign hr_ok  = (hour_in1 < 2'd2 && hour_in0 <= 4'd9) || (hour_in1 == 2'd2 && hour_in0 <= 4'd3);
   assign in_ok  = hr_ok && (min_in1 <= 4'd5) && (min_in0 <= 4'd9);
   assign sel_ok = {1'b0, alarm_sel} < (AW+1)'(NUM_ALARMS);
   assign ts_ok  = time_set && in_ok;
   // time_set takes priority: a simultaneous alarm_set is dropped silently
   assign as_ok  = alarm_set && !time_set && in_ok && sel_ok;
   assign in_vec = {hour_in1, hour_in0, min_in1, min_in0};

   assign tick     = (pre_q == PW'(CLK_PER_SEC - 1));
   assign adv      = tick && !ts_ok;
   assign min_tick = adv && (s1_q == 4'd5) && (s0_q == 4'd9);
   assign t_next   = {h1_d, h0_d, m1_d, m0_d};

   assign set_err_d = (time_set && !in_ok) || (alarm_set && !time_set && !(in_ok && sel_ok));

   always_comb begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      h1_d = h1_q; h0_d = h0_q; m1_d = m1_q; m0_d = m0_q; s1_d = s1_q; s0_d = s0_q;
      if (ts_ok) begin
         pre_d = '0;
         h1_d = hour_in1; h0_d = hour_in0; m1_d = min_in1; m0_d = min_in0;
         s1_d = '0; s0_d = '0;
      end else if (tick) begin
         s0_d = s0_q + 4'd1;
         if (s0_q == 4'd9) begin
            s0_d = '0;
            s1_d = s1_q + 4'd1;
            if (s1_q == 4'd5) begin
               s1_d = '0;
               m0_d = m0_q + 4'd1;
               if (m0_q == 4'd9) begin
                  m0_d = '0;
                  m1_d = m1_q + 4'd1;
                  if (m1_q == 4'd5) begin
                     m1_d = '0;
                     h0_d = h0_q + 4'd1;
                     if (h1_q == 2'd2 && h0_q == 4'd3) begin
                        h1_d = '0;
                        h0_d = '0;
                     end else if (h0_q == 4'd9) begin
                        h0_d = '0;
                        h1_d = h1_q + 2'd1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pre_q <= '0;
         h1_q <= '0; h0_q <= '0; m1_q <= '0; m0_q <= '0; s1_q <= '0; s0_q <= '0;
         alm_q       <= '0;
         alarm_q     <= '0;
         alarm_any_q <= 1'b0;
         set_err_q   <= 1'b0;
      end else begin
         pre_q <= pre_d;
         h1_q <= h1_d; h0_q <= h0_d; m1_q <= m1_d; m0_q <= m0_d; s1_q <= s1_d; s0_q <= s0_d;
         if (as_ok) alm_q[alarm_sel] <= in_vec;
         alarm_q     <= ring;
         alarm_any_q <= |ring;
         set_err_q   <= set_err_d;
      end
   end

   for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
      logic [1:0]    st_q, st_d;
      logic [RW-1:0] rc_q, rc_d;
      logic          hit;
`ifdef SNOOZE_EN
      logic [SW-1:0] sc_q, sc_d;
`endif

      // match only on a tick that rolls the seconds over onto the alarm minute
      assign hit     = min_tick && alarm_on[g] && (t_next == alm_q[g]);
      assign ring[g] = (st_q == ST_RING);

      always_comb begin
         st_d = st_q;
         rc_d = rc_q;
`ifdef SNOOZE_EN
         sc_d = sc_q;
`endif
         case (st_q)
            ST_RING: begin
               if (stop || !alarm_on[g]) st_d = ST_IDLE;
`ifdef SNOOZE_EN
               else if (snooze) begin
                  st_d = ST_SNZ;
                  sc_d = '0;
                  rc_d = '0;
               end
`endif
               else if (adv) begin
                  if (rc_q == RW'(RING_SEC - 1)) st_d = ST_IDLE;
                  else rc_d = rc_q + RW'(1);
               end
            end
`ifdef SNOOZE_EN
            ST_SNZ: begin
               if (stop || !alarm_on[g]) st_d = ST_IDLE;
               else if (hit) begin
                  st_d = ST_RING;
                  rc_d = '0;
               end else if (adv) begin
                  if (sc_q == SW'(SNZ_TICKS - 1)) begin
                     st_d = ST_RING;
                     rc_d = '0;
                  end else sc_d = sc_q + SW'(1);
               end
            end
`endif
            default: begin
               st_d = ST_IDLE;
               if (hit) begin
                  st_d = ST_RING;
                  rc_d = '0;
               end
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            st_q <= ST_IDLE;
            rc_q <= '0;
`ifdef SNOOZE_EN
            sc_q <= '0;
`endif
         end else begin
            st_q <= st_d;
            rc_q <= rc_d;
`ifdef SNOOZE_EN
            sc_q <= sc_d;
`endif
         end
      end
   end

   assign alarm     = alarm_q;
   assign alarm_any = alarm_any_q;
   assign set_err   = set_err_q;
   assign hour_out1 = h1_q;
   assign hour_out0 = h0_q;
   assign min_out1  = m1_q;
   assign min_out0  = m0_q;
   assign sec_out1  = s1_q;
   assign sec_out0  = s0_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock: 4 channels, 4 clk per second, 6 s ring, 1 min snooze.
module tb_multi_alarm_clock;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] hour_in1;
   logic [3:0] hour_in0, min_in1, min_in0;
   logic       time_set, alarm_set;
   logic [1:0] alarm_sel;
   logic [3:0] alarm_on;
   logic       stop, snooze;
   logic [3:0] alarm;
   logic       alarm_any, set_err;
   logic [1:0] hour_out1;
   logic [3:0] hour_out0, min_out1, min_out0, sec_out1, sec_out0;

   int total = 0;
   int bad   = 0;

   multi_alarm_clock #(.NUM_ALARMS(4), .CLK_PER_SEC(4), .RING_SEC(6), .SNOOZE_MIN(1)) dut (
      .clk(clk), .reset(reset),
      .hour_in1(hour_in1), .hour_in0(hour_in0), .min_in1(min_in1), .min_in0(min_in0),
      .time_set(time_set), .alarm_set(alarm_set), .alarm_sel(alarm_sel), .alarm_on(alarm_on),
      .stop(stop), .snooze(snooze),
      .alarm(alarm), .alarm_any(alarm_any), .set_err(set_err),
      .hour_out1(hour_out1), .hour_out0(hour_out0), .min_out1(min_out1), .min_out0(min_out0),
      .sec_out1(sec_out1), .sec_out0(sec_out0)
   );

   always #5 clk = ~clk;

   function automatic logic [21:0] mk(input int h1, input int h0, input int m1, input int m0,
                                      input int s1, input int s0);
      return {h1[1:0], h0[3:0], m1[3:0], m0[3:0], s1[3:0], s0[3:0]};
   endfunction

   function automatic logic [21:0] now_t();
      return {hour_out1, hour_out0, min_out1, min_out0, sec_out1, sec_out0};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input int h1, input int h0, input int m1, input int m0);
      hour_in1 = h1[1:0]; hour_in0 = h0[3:0]; min_in1 = m1[3:0]; min_in0 = m0[3:0];
   endtask

   task automatic set_time(input int h1, input int h0, input int m1, input int m0);
      drive_in(h1, h0, m1, m0);
      time_set = 1'b1;
      step(1);
      time_set = 1'b0;
   endtask

   task automatic set_alarm(input int sel, input int h1, input int h0, input int m1, input int m0);
      drive_in(h1, h0, m1, m0);
      alarm_sel = sel[1:0];
      alarm_set = 1'b1;
      step(1);
      alarm_set = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive_in(1, 2, 3, 4);
      time_set = 1'b1;
      step(2);
      time_set = 1'b0;
      total++; if (now_t() !== mk(0,0,0,0,0,0)) begin bad++; $display("FAIL reset_time got=%h exp=%h", now_t(), mk(0,0,0,0,0,0)); end
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL reset_alarm got=%b exp=0000", alarm); end
      total++; if (alarm_any !== 1'b0) begin bad++; $display("FAIL reset_any got=%b exp=0", alarm_any); end
      total++; if (set_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", set_err); end
      reset = 1'b1;
   endtask

   task automatic test_prescaler();
      set_time(1, 7, 2, 2);
      total++; if (now_t() !== mk(1,7,2,2,0,0)) begin bad++; $display("FAIL load_time got=%h exp=%h", now_t(), mk(1,7,2,2,0,0)); end
      step(3);
      total++; if (now_t() !== mk(1,7,2,2,0,0)) begin bad++; $display("FAIL pre_hold got=%h exp=%h", now_t(), mk(1,7,2,2,0,0)); end
      step(1);
      total++; if (now_t() !== mk(1,7,2,2,0,1)) begin bad++; $display("FAIL pre_tick1 got=%h exp=%h", now_t(), mk(1,7,2,2,0,1)); end
      step(4);
      total++; if (now_t() !== mk(1,7,2,2,0,2)) begin bad++; $display("FAIL pre_tick2 got=%h exp=%h", now_t(), mk(1,7,2,2,0,2)); end
   endtask

   task automatic test_wrap();
      set_time(2, 3, 5, 9);
      step(236);
      total++; if (now_t() !== mk(2,3,5,9,5,9)) begin bad++; $display("FAIL wrap_pre got=%h exp=%h", now_t(), mk(2,3,5,9,5,9)); end
      step(4);
      total++; if (now_t() !== mk(0,0,0,0,0,0)) begin bad++; $display("FAIL wrap_day got=%h exp=%h", now_t(), mk(0,0,0,0,0,0)); end
   endtask

   task automatic test_match();
      set_alarm(0, 1, 7, 2, 3);
      set_alarm(1, 1, 7, 2, 3);
      set_alarm(2, 1, 7, 2, 3);
      alarm_on = 4'b0101;
      set_time(1, 7, 2, 2);
      step(236);
      total++; if (now_t() !== mk(1,7,2,2,5,9)) begin bad++; $display("FAIL match_pre got=%h exp=%h", now_t(), mk(1,7,2,2,5,9)); end
      step(4);
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL match_latency got=%b exp=0000", alarm); end
      step(1);
      total++; if (alarm !== 4'b0101) begin bad++; $display("FAIL match_ring got=%b exp=0101", alarm); end
      total++; if (alarm_any !== 1'b1) begin bad++; $display("FAIL match_any got=%b exp=1", alarm_any); end
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(1);
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL match_stop got=%b exp=0000", alarm); end
      total++; if (alarm_any !== 1'b0) begin bad++; $display("FAIL match_stop_any got=%b exp=0", alarm_any); end
      alarm_on = 4'b0000;
   endtask

   task automatic test_timeout();
      int first = -1;
      int cnt   = 0;
      set_alarm(1, 2, 1, 4, 5);
      alarm_on = 4'b0010;
      set_time(2, 1, 4, 4);
      step(236);
      for (int i = 1; i <= 60; i++) begin
         step(1);
         if (alarm[1] === 1'b1) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      total++; if (first !== 5) begin bad++; $display("FAIL timeout_rise got=%0d exp=5", first); end
      total++; if (cnt !== 24) begin bad++; $display("FAIL timeout_len got=%0d exp=24", cnt); end
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL timeout_end got=%b exp=0000", alarm); end
      alarm_on = 4'b0000;
   endtask

   task automatic test_set_err();
      set_time(1, 0, 0, 0);
      drive_in(2, 4, 0, 0);
      time_set = 1'b1;
      step(1);
      time_set = 1'b0;
      total++; if (set_err !== 1'b1) begin bad++; $display("FAIL err_hour got=%b exp=1", set_err); end
      total++; if (now_t() !== mk(1,0,0,0,0,0)) begin bad++; $display("FAIL err_hour_time got=%h exp=%h", now_t(), mk(1,0,0,0,0,0)); end
      step(1);
      total++; if (set_err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0", set_err); end
      drive_in(0, 0, 6, 0);
      time_set = 1'b1;
      step(1);
      time_set = 1'b0;
      total++; if (set_err !== 1'b1) begin bad++; $display("FAIL err_min got=%b exp=1", set_err); end
      total++; if (now_t() !== mk(1,0,0,0,0,0)) begin bad++; $display("FAIL err_min_time got=%h exp=%h", now_t(), mk(1,0,0,0,0,0)); end
      set_alarm(0, 1, 10, 0, 0);
      total++; if (set_err !== 1'b1) begin bad++; $display("FAIL err_alarm got=%b exp=1", set_err); end
   endtask

   task automatic test_no_trigger_on_load();
      set_alarm(3, 2, 1, 2, 5);
      alarm_on = 4'b1000;
      set_time(2, 1, 2, 5);
      step(8);
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL load_no_ring got=%b exp=0000", alarm); end
      drive_in(1, 3, 0, 0);
      alarm_sel = 2'd3;
      time_set  = 1'b1;
      alarm_set = 1'b1;
      step(1);
      time_set  = 1'b0;
      alarm_set = 1'b0;
      total++; if (set_err !== 1'b0) begin bad++; $display("FAIL both_err got=%b exp=0", set_err); end
      total++; if (now_t() !== mk(1,3,0,0,0,0)) begin bad++; $display("FAIL both_time got=%h exp=%h", now_t(), mk(1,3,0,0,0,0)); end
      set_time(2, 1, 2, 4);
      step(241);
      total++; if (alarm !== 4'b1000) begin bad++; $display("FAIL both_kept_alarm got=%b exp=1000", alarm); end
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(1);
      alarm_on = 4'b0000;
   endtask

   task automatic test_snooze();
      set_alarm(0, 0, 8, 0, 0);
      alarm_on = 4'b0001;
      set_time(0, 7, 5, 9);
      step(241);
      total++; if (alarm !== 4'b0001) begin bad++; $display("FAIL snz_ring got=%b exp=0001", alarm); end
      snooze = 1'b1;
      step(1);
      snooze = 1'b0;
      step(1);
`ifdef SNOOZE_EN
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL snz_quiet got=%b exp=0000", alarm); end
      step(237);
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL snz_end_quiet got=%b exp=0000", alarm); end
      step(1);
      total++; if (alarm !== 4'b0001) begin bad++; $display("FAIL snz_rering got=%b exp=0001", alarm); end
      stop   = 1'b1;
      snooze = 1'b1;
      step(1);
      stop   = 1'b0;
      snooze = 1'b0;
      step(1);
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL snz_stop_wins got=%b exp=0000", alarm); end
      step(8);
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL snz_idle got=%b exp=0000", alarm); end
`else
      total++; if (alarm !== 4'b0001) begin bad++; $display("FAIL snz_ignored got=%b exp=0001", alarm); end
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      step(1);
      total++; if (alarm !== 4'b0000) begin bad++; $display("FAIL snz_stop got=%b exp=0000", alarm); end
`endif
      alarm_on = 4'b0000;
   endtask

   initial begin
      reset = 1'b0;
      drive_in(0, 0, 0, 0);
      time_set = 1'b0; alarm_set = 1'b0; alarm_sel = 2'd0;
      alarm_on = 4'b0000; stop = 1'b0; snooze = 1'b0;
      #1;
      test_reset();
      test_prescaler();
      test_wrap();
      test_match();
      test_timeout();
      test_set_err();
      test_no_trigger_on_load();
      test_snooze();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
